// File: rtl/rsi_window_feeder.sv
// RSI front end: per-sample gain/loss deltas kept in two N-deep
// sliding windows, strobed out once the windows are full.
package rsi_pkg;
    typedef logic [15:0] uq8_8_t;
endpackage

module rsi_window_feeder
    import rsi_pkg::*;
#(
    parameter int N = 14
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  uq8_8_t                 i_price,
    output uq8_8_t                 o_gains  [N],
    output uq8_8_t                 o_losses [N],
    output logic                   o_valid,
    output logic [$clog2(N+1)-1:0] o_fill
);

    localparam int FW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_FULL
    } state_e;

    state_e  state_q, state_d;
    uq8_8_t  prev_q, prev_d;
    uq8_8_t  gains_q  [N];
    uq8_8_t  gains_d  [N];
    uq8_8_t  losses_q [N];
    uq8_8_t  losses_d [N];
    logic    valid_q, valid_d;
    logic [FW-1:0] fill_q, fill_d;

    uq8_8_t  gain_new;
    uq8_8_t  loss_new;

    always_comb begin
        gain_new = '0;
        loss_new = '0;
        if (i_price > prev_q) begin
            gain_new = i_price - prev_q;
        end else if (i_price < prev_q) begin
            loss_new = prev_q - i_price;
        end
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        gains_d  = gains_q;
        losses_d = losses_q;
        fill_d   = fill_q;
        valid_d  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (i_valid) begin
                    prev_d  = i_price;
                    state_d = S_FILL;
                end
            end
            S_FILL, S_FULL: begin
                if (i_valid) begin
                    // newest at [0]; oldest drops off [N-1]
                    for (int k = N - 1; k > 0; k--) begin
                        gains_d[k]  = gains_q[k-1];
                        losses_d[k] = losses_q[k-1];
                    end
                    gains_d[0]  = gain_new;
                    losses_d[0] = loss_new;
                    prev_d      = i_price;
                    if (state_q == S_FULL) begin
                        valid_d = 1'b1;
                    end else begin
                        fill_d = fill_q + 1'b1;
                        if (fill_q == FW'(N - 1)) begin
                            state_d = S_FULL;
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_EMPTY;
            prev_q   <= '0;
            gains_q  <= '{default: '0};
            losses_q <= '{default: '0};
            fill_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            gains_q  <= gains_d;
            losses_q <= losses_d;
            fill_q   <= fill_d;
            valid_q  <= valid_d;
        end
    end

    assign o_gains  = gains_q;
    assign o_losses = losses_q;
    assign o_valid  = valid_q;
    assign o_fill   = fill_q;

endmodule

// File: tb/tb_rsi_window_feeder.sv
// Directed bench for rsi_window_feeder: reset, ramp, mixed deltas,
// steady slide, gapped input and reset mid-fill.
module tb_rsi_window_feeder;
    import rsi_pkg::*;

    localparam int N = 14;

    logic   i_clk;
    logic   i_rst;
    logic   i_valid;
    uq8_8_t i_price;
    uq8_8_t o_gains  [N];
    uq8_8_t o_losses [N];
    logic   o_valid;
    logic [3:0] o_fill;

    int n_assert;
    int n_fail;

    rsi_window_feeder #(.N(N)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_price  (i_price),
        .o_gains  (o_gains),
        .o_losses (o_losses),
        .o_valid  (o_valid),
        .o_fill   (o_fill)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic cyc(input logic rst, input logic v,
                       input logic [15:0] p);
        i_rst   = rst;
        i_valid = v;
        i_price = p;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [15:0] g,
                           input logic [15:0] l);
        for (int j = 0; j < N; j++) begin
            chk($sformatf("%s_g%0d", tag, j), 32'(o_gains[j]), 32'(g));
            chk($sformatf("%s_l%0d", tag, j), 32'(o_losses[j]), 32'(l));
        end
    endtask

    function automatic logic [15:0] gof(input logic [15:0] p,
                                        input logic [15:0] q);
        return (p > q) ? p - q : 16'h0000;
    endfunction

    function automatic logic [15:0] lof(input logic [15:0] p,
                                        input logic [15:0] q);
        return (p < q) ? q - p : 16'h0000;
    endfunction

    logic [15:0] sp [1:30];
    logic [15:0] snap_g0, snap_l0, snap_g13;
    int          vcount;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_price  = '0;

        // reset held 3 cycles with live samples
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 16'h1111 * 16'(i + 1));
            chk("rst_valid", 32'(o_valid), 0);
            chk("rst_fill", 32'(o_fill), 0);
            chk_win("rst_win", 16'h0000, 16'h0000);
        end
        cyc(1'b0, 1'b0, 16'h0000);
        chk("post_rst_valid", 32'(o_valid), 0);
        chk("post_rst_fill", 32'(o_fill), 0);

        // rising ramp
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b0, 1'b1, 16'h6400 + 16'(k - 1) * 16'h0100);
            chk($sformatf("ramp_valid%0d", k), 32'(o_valid),
                (k == 15) ? 1 : 0);
            chk($sformatf("ramp_fill%0d", k), 32'(o_fill), k - 1);
        end
        chk_win("ramp_win", 16'h0100, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);
        chk("ramp_idle_valid", 32'(o_valid), 0);
        chk("ramp_idle_fill", 32'(o_fill), 14);

        // mixed deltas
        cyc(1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 16'h1400);
        chk("mix_fill1", 32'(o_fill), 0);
        cyc(1'b0, 1'b1, 16'h1380);
        chk("mix2_l0", 32'(o_losses[0]), 32'h0080);
        chk("mix2_g0", 32'(o_gains[0]), 0);
        cyc(1'b0, 1'b1, 16'h1380);
        chk("mix3_l0", 32'(o_losses[0]), 0);
        chk("mix3_g0", 32'(o_gains[0]), 0);
        cyc(1'b0, 1'b1, 16'h1500);
        chk("mix4_g0", 32'(o_gains[0]), 32'h0180);
        chk("mix4_l0", 32'(o_losses[0]), 0);
        chk("mix4_l2", 32'(o_losses[2]), 32'h0080);
        chk("mix4_l1", 32'(o_losses[1]), 0);
        chk("mix4_fill", 32'(o_fill), 3);
        chk("mix4_valid", 32'(o_valid), 0);

        // steady stream of 30 samples
        for (int i = 1; i <= 30; i++) begin
            sp[i] = 16'h3000 + 16'((i * 53) % 97) * 16'h0040;
        end
        cyc(1'b1, 1'b0, 16'h0000);
        vcount = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc(1'b0, 1'b1, sp[k]);
            if (o_valid === 1'b1) vcount++;
            chk($sformatf("stream_valid%0d", k), 32'(o_valid),
                (k >= 15) ? 1 : 0);
        end
        chk("stream_vcount", 32'(vcount), 16);
        for (int j = 0; j < N; j++) begin
            chk($sformatf("slide_g%0d", j), 32'(o_gains[j]),
                32'(gof(sp[30-j], sp[29-j])));
            chk($sformatf("slide_l%0d", j), 32'(o_losses[j]),
                32'(lof(sp[30-j], sp[29-j])));
        end

        // gapped input once full
        cyc(1'b0, 1'b1, 16'h5000);
        chk("gap1_valid", 32'(o_valid), 1);
        chk("gap1_g0", 32'(o_gains[0]), 32'(16'h5000 - sp[30]));
        snap_g0  = o_gains[0];
        snap_l0  = o_losses[0];
        snap_g13 = o_gains[13];
        for (int c = 2; c <= 3; c++) begin
            cyc(1'b0, 1'b0, 16'hDEAD);
            chk($sformatf("gap%0d_valid", c), 32'(o_valid), 0);
            chk($sformatf("gap%0d_fill", c), 32'(o_fill), 14);
            chk($sformatf("gap%0d_g0", c), 32'(o_gains[0]),
                32'(snap_g0));
            chk($sformatf("gap%0d_l0", c), 32'(o_losses[0]),
                32'(snap_l0));
            chk($sformatf("gap%0d_g13", c), 32'(o_gains[13]),
                32'(snap_g13));
        end
        cyc(1'b0, 1'b1, 16'h4F00);
        chk("gap4_valid", 32'(o_valid), 1);
        chk("gap4_l0", 32'(o_losses[0]), 32'h0100);
        chk("gap4_g1", 32'(o_gains[1]), 32'(snap_g0));
        cyc(1'b0, 1'b0, 16'hBEEF);
        chk("gap5_valid", 32'(o_valid), 0);
        chk("gap5_l0", 32'(o_losses[0]), 32'h0100);
        cyc(1'b0, 1'b1, 16'h5200);
        chk("gap6_valid", 32'(o_valid), 1);
        chk("gap6_g0", 32'(o_gains[0]), 32'h0300);
        chk("gap6_l1", 32'(o_losses[1]), 32'h0100);
        chk("gap6_fill", 32'(o_fill), 14);

        // reset mid-fill
        cyc(1'b1, 1'b0, 16'h0000);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b1, 16'h7000 + 16'(k) * 16'h0230);
        end
        chk("mid_fill_pre", 32'(o_fill), 9);
        cyc(1'b1, 1'b1, 16'h9999);
        chk("mid_rst_fill", 32'(o_fill), 0);
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk_win("mid_rst_win", 16'h0000, 16'h0000);
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b0, 1'b1, 16'h2000 - 16'(k) * 16'h0010);
            chk($sformatf("refill_valid%0d", k), 32'(o_valid),
                (k == 15) ? 1 : 0);
            chk($sformatf("refill_fill%0d", k), 32'(o_fill), k - 1);
            if (k == 10) begin
                chk("stale_l9", 32'(o_losses[9]), 0);
                chk("stale_g9", 32'(o_gains[9]), 0);
                chk("stale_l13", 32'(o_losses[13]), 0);
                chk("fresh_l8", 32'(o_losses[8]), 32'h0010);
            end
        end
        chk_win("refill_win", 16'h0000, 16'h0010);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
